// File: rtl/ld_st_issue_queue_pkg.sv
// Shared load/store issue types (ld_st_fifo_data, cdb_bfm), opcode constants
// and the operand-readiness rule used by ld_st_issue_queue.
package ld_st_issue_queue_pkg;

  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;
  localparam int IMM_W  = 32;

  localparam logic LD_OP = 1'b0;
  localparam logic ST_OP = 1'b1;

  typedef struct packed {
    logic [TAG_W-1:0]  rs1_tag;
    logic [DATA_W-1:0] rs1_data;
    logic              rs1_data_valid;
    logic [TAG_W-1:0]  rs2_tag;
    logic [DATA_W-1:0] rs2_data;
    logic              rs2_data_valid;
    logic [TAG_W-1:0]  rd_tag;
  } common_data_t;

  typedef struct packed {
    common_data_t     common_data;
    logic [IMM_W-1:0] immediate;
    logic             ld_st_opcode;
  } ld_st_fifo_data;

  typedef struct packed {
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_result;
  } cdb_bfm;

  // Loads only need the address base; stores also need the store data.
  function automatic logic operands_ready(input ld_st_fifo_data e);
    return e.common_data.rs1_data_valid &&
           ((e.ld_st_opcode == LD_OP) || e.common_data.rs2_data_valid);
  endfunction

endpackage

// File: rtl/ld_st_issue_queue_wakeup.sv
// Combinational CDB tag compare and operand merge for one queue entry.
module ld_st_wakeup
  import ld_st_issue_queue_pkg::*;
(
  input  ld_st_fifo_data entry_i,
  input  cdb_bfm         cdb_i,
  output ld_st_fifo_data entry_o
);

  always_comb begin
    entry_o = entry_i;
    if (cdb_i.cdb_valid && !entry_i.common_data.rs1_data_valid &&
        (cdb_i.cdb_tag == entry_i.common_data.rs1_tag)) begin
      entry_o.common_data.rs1_data       = cdb_i.cdb_result;
      entry_o.common_data.rs1_data_valid = 1'b1;
    end
    if (cdb_i.cdb_valid && !entry_i.common_data.rs2_data_valid &&
        (cdb_i.cdb_tag == entry_i.common_data.rs2_tag)) begin
      entry_o.common_data.rs2_data       = cdb_i.cdb_result;
      entry_o.common_data.rs2_data_valid = 1'b1;
    end
  end

endmodule

// File: rtl/ld_st_issue_queue.sv
// In-order load/store issue queue with CDB operand capture.
// Define LSQ_CDB_BYPASS_EN to forward a same-cycle CDB match to the issue outputs.
module ld_st_issue_queue
  import ld_st_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_dispatch_en,
  input  ld_st_fifo_data i_dispatch_data,
  input  cdb_bfm         i_cdb,
  input  logic           i_issue_granted,
  input  logic           i_flush,
  output logic           o_issue_req,
  output ld_st_fifo_data o_issue_data,
  output logic           o_full,
  output logic           o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  ld_st_fifo_data   entry_q [DEPTH];
  ld_st_fifo_data   woken   [DEPTH];
  ld_st_fifo_data   disp_woken;
  ld_st_fifo_data   head;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty, full, head_rdy, push, pop;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry_wakeup
    ld_st_wakeup u_wakeup (
      .entry_i (entry_q[i]),
      .cdb_i   (i_cdb),
      .entry_o (woken[i])
    );
  end

  ld_st_wakeup u_disp_wakeup (
    .entry_i (i_dispatch_data),
    .cdb_i   (i_cdb),
    .entry_o (disp_woken)
  );

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

`ifdef LSQ_CDB_BYPASS_EN
  assign head = woken[rd_ptr_q];
`else
  assign head = entry_q[rd_ptr_q];
`endif

  assign head_rdy     = valid_q[rd_ptr_q] && operands_ready(head);
  assign o_issue_req  = !empty && head_rdy;
  assign o_issue_data = empty ? '0 : head;
  assign o_full       = full;
  assign o_empty      = empty;
  assign o_count      = count_q;

  // Flush wins over everything; a full queue drops dispatch even on a pop cycle.
  assign push = i_dispatch_en && !full && !i_flush;
  assign pop  = i_issue_granted && o_issue_req && !i_flush;

  always_comb begin
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      valid_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        valid_d[wr_ptr_q] = 1'b1;
        wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        valid_d[rd_ptr_q] = 1'b0;
        rd_ptr_d          = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload is unreset; every entry recaptures its woken copy each cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_q[i] <= woken[i];
    end
    if (push) begin
      entry_q[wr_ptr_q] <= disp_woken;
    end
  end

endmodule

// File: tb/tb_ld_st_issue_queue.sv
// Directed scoreboard bench for ld_st_issue_queue (both bypass configurations).
module tb_ld_st_issue_queue;
  import ld_st_issue_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_dispatch_en;
  ld_st_fifo_data   i_dispatch_data;
  cdb_bfm           i_cdb;
  logic             i_issue_granted;
  logic             i_flush;
  logic             o_issue_req;
  ld_st_fifo_data   o_issue_data;
  logic             o_full;
  logic             o_empty;
  logic [CNT_W-1:0] o_count;

  ld_st_fifo_data sb[$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ld_st_issue_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_dispatch_en   (i_dispatch_en),
    .i_dispatch_data (i_dispatch_data),
    .i_cdb           (i_cdb),
    .i_issue_granted (i_issue_granted),
    .i_flush         (i_flush),
    .o_issue_req     (o_issue_req),
    .o_issue_data    (o_issue_data),
    .o_full          (o_full),
    .o_empty         (o_empty),
    .o_count         (o_count)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic ld_st_fifo_data mk(input logic op,
      input logic [5:0] t1, input logic [31:0] d1, input logic v1,
      input logic [5:0] t2, input logic [31:0] d2, input logic v2,
      input logic [5:0] rd, input logic [31:0] imm);
    ld_st_fifo_data r;
    r = '0;
    r.common_data.rs1_tag        = t1;
    r.common_data.rs1_data       = d1;
    r.common_data.rs1_data_valid = v1;
    r.common_data.rs2_tag        = t2;
    r.common_data.rs2_data       = d2;
    r.common_data.rs2_data_valid = v2;
    r.common_data.rd_tag         = rd;
    r.immediate                  = imm;
    r.ld_st_opcode               = op;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input ld_st_fifo_data e);
    i_dispatch_en   = 1'b1;
    i_dispatch_data = e;
    tick();
    i_dispatch_en   = 1'b0;
  endtask

  task automatic set_cdb(input logic [5:0] tag, input logic [31:0] res);
    i_cdb.cdb_valid  = 1'b1;
    i_cdb.cdb_tag    = tag;
    i_cdb.cdb_result = res;
  endtask

  task automatic grant_head(input string tag);
    ld_st_fifo_data exp;
    chk({tag, "_req"}, 128'(o_issue_req), 128'(1));
    n_vec++;
    assert (sb.size() != 0) else begin
      n_err++;
      $error("FAIL %s_sb: observed empty scoreboard, expected an entry", tag);
    end
    if (sb.size() != 0) begin
      exp = sb.pop_front();
      chk({tag, "_data"}, 128'(o_issue_data), 128'(exp));
    end
    i_issue_granted = 1'b1;
    tick();
    i_issue_granted = 1'b0;
  endtask

  ld_st_fifo_data e, e0, e1, e2, e3;

  initial begin
    rst_n           = 1'b0;
    i_dispatch_en   = 1'b0;
    i_dispatch_data = '0;
    i_cdb           = '0;
    i_issue_granted = 1'b0;
    i_flush         = 1'b0;
    repeat (2) tick();
    chk("rst_empty", 128'(o_empty), 128'(1));
    chk("rst_full",  128'(o_full),  128'(0));
    chk("rst_count", 128'(o_count), 128'(0));
    chk("rst_req",   128'(o_issue_req), 128'(0));
    chk("rst_data",  128'(o_issue_data), 128'(0));
    rst_n = 1'b1;
    tick();

    // ready store issues the cycle after dispatch
    e = mk(ST_OP, 6'd0, 32'h10, 1'b1, 6'd0, 32'hAB, 1'b1, 6'd1, 32'd4);
    dispatch(e);
    sb.push_back(e);
    chk("st_count", 128'(o_count), 128'(1));
    grant_head("st");
    chk("st_empty", 128'(o_empty), 128'(1));
    chk("st_count0", 128'(o_count), 128'(0));

    // load waiting on rs1 tag 5
    e = mk(LD_OP, 6'd5, 32'h0, 1'b0, 6'd0, 32'h0, 1'b1, 6'd2, 32'd8);
    dispatch(e);
    chk("ld_wait_req", 128'(o_issue_req), 128'(0));
    set_cdb(6'd5, 32'h20);
    #1;
`ifdef LSQ_CDB_BYPASS_EN
    chk("ld_byp_req", 128'(o_issue_req), 128'(1));
    chk("ld_byp_rs1", 128'(o_issue_data.common_data.rs1_data), 128'(32'h20));
`else
    chk("ld_same_req", 128'(o_issue_req), 128'(0));
`endif
    tick();
    i_cdb = '0;
    e.common_data.rs1_data       = 32'h20;
    e.common_data.rs1_data_valid = 1'b1;
    sb.push_back(e);
    grant_head("ld_wake");

    // broadcast coinciding with dispatch of a store missing rs2
    e = mk(ST_OP, 6'd0, 32'h30, 1'b1, 6'd3, 32'h0, 1'b0, 6'd3, 32'd0);
    set_cdb(6'd3, 32'h55);
    dispatch(e);
    i_cdb = '0;
    e.common_data.rs2_data       = 32'h55;
    e.common_data.rs2_data_valid = 1'b1;
    sb.push_back(e);
    grant_head("st_coinc");

    // asynchronous reset with three entries held
    for (int i = 0; i < 3; i++) begin
      dispatch(mk(LD_OP, 6'd0, 32'(i), 1'b1, 6'd0, 32'h0, 1'b1, 6'd9, 32'd0));
    end
    chk("mid_count3", 128'(o_count), 128'(3));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 128'(o_count), 128'(0));
    chk("mid_rst_empty", 128'(o_empty), 128'(1));
    chk("mid_rst_req",   128'(o_issue_req), 128'(0));
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();

    // fill with head unready, entry 2 ready
    e0 = mk(LD_OP, 6'd7, 32'h0, 1'b0, 6'd0, 32'h0, 1'b1, 6'd4, 32'h100);
    e1 = mk(LD_OP, 6'd8, 32'h0, 1'b0, 6'd0, 32'h0, 1'b1, 6'd5, 32'h104);
    e2 = mk(ST_OP, 6'd0, 32'h40, 1'b1, 6'd0, 32'h41, 1'b1, 6'd6, 32'h108);
    e3 = mk(LD_OP, 6'd9, 32'h0, 1'b0, 6'd0, 32'h0, 1'b1, 6'd7, 32'h10C);
    dispatch(e0);
    dispatch(e1);
    dispatch(e2);
    dispatch(e3);
    chk("fill_count", 128'(o_count), 128'(4));
    chk("fill_full",  128'(o_full), 128'(1));
    chk("fill_req",   128'(o_issue_req), 128'(0));
    dispatch(mk(ST_OP, 6'd0, 32'hEE, 1'b1, 6'd0, 32'hEF, 1'b1, 6'd8, 32'd0));
    chk("drop_count", 128'(o_count), 128'(4));
    i_issue_granted = 1'b1;
    tick();
    i_issue_granted = 1'b0;
    chk("nogrant_count", 128'(o_count), 128'(4));
    set_cdb(6'd8, 32'h80);
    tick();
    i_cdb = '0;
    chk("inorder_req1", 128'(o_issue_req), 128'(0));
    set_cdb(6'd9, 32'h90);
    tick();
    i_cdb = '0;
    chk("inorder_req2", 128'(o_issue_req), 128'(0));
    set_cdb(6'd7, 32'h70);
    #1;
`ifdef LSQ_CDB_BYPASS_EN
    chk("head_byp_req", 128'(o_issue_req), 128'(1));
`else
    chk("head_same_req", 128'(o_issue_req), 128'(0));
`endif
    tick();
    i_cdb = '0;
    e0.common_data.rs1_data = 32'h70; e0.common_data.rs1_data_valid = 1'b1;
    e1.common_data.rs1_data = 32'h80; e1.common_data.rs1_data_valid = 1'b1;
    e3.common_data.rs1_data = 32'h90; e3.common_data.rs1_data_valid = 1'b1;
    sb.push_back(e0);
    sb.push_back(e1);
    sb.push_back(e2);
    sb.push_back(e3);
    for (int i = 0; i < 4; i++) begin
      grant_head($sformatf("b2b%0d", i));
    end
    chk("b2b_empty", 128'(o_empty), 128'(1));
    e = mk(ST_OP, 6'd0, 32'h60, 1'b1, 6'd0, 32'h61, 1'b1, 6'd10, 32'h20);
    dispatch(e);
    sb.push_back(e);
    chk("wrap_count", 128'(o_count), 128'(1));
    grant_head("wrap");

    // flush beats a same-cycle dispatch and grant
    dispatch(mk(LD_OP, 6'd0, 32'hA0, 1'b1, 6'd0, 32'h0, 1'b1, 6'd11, 32'd0));
    chk("fl_pre_count", 128'(o_count), 128'(1));
    i_flush         = 1'b1;
    i_dispatch_en   = 1'b1;
    i_dispatch_data = mk(LD_OP, 6'd0, 32'hB0, 1'b1, 6'd0, 32'h0, 1'b1, 6'd12, 32'd0);
    i_issue_granted = 1'b1;
    tick();
    i_flush         = 1'b0;
    i_dispatch_en   = 1'b0;
    i_issue_granted = 1'b0;
    chk("fl_count", 128'(o_count), 128'(0));
    chk("fl_empty", 128'(o_empty), 128'(1));
    chk("fl_req",   128'(o_issue_req), 128'(0));
    chk("fl_data",  128'(o_issue_data), 128'(0));
    sb.delete();
    tick();
    chk("fl_hold_count", 128'(o_count), 128'(0));
    e = mk(LD_OP, 6'd0, 32'hC0, 1'b1, 6'd0, 32'h0, 1'b1, 6'd13, 32'h4);
    dispatch(e);
    sb.push_back(e);
    chk("post_fl_count", 128'(o_count), 128'(1));
    grant_head("post_fl");
    chk("post_fl_empty", 128'(o_empty), 128'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
